mem_stage_sequencer: RTL and testbench
======================================

// Module: mem_stage_sequencer
// PURPOSE
// Control FSM in front of the memory stage. Turns one decoded memory op (LDD/STD/PUSH/POP/CALL/RET/RTI) or an irq into per-cycle strobes.
// - Strobes: read/write/push/pop, address select, write-source select, PC-source select.
// - Multi-word stack sequences (CALL/RET/RTI/irq) run over several cycles while the pipeline is held with stall.
// PARAMETERS
// STACK_DEPTH  1024  stack words; used only by STACK_GUARD_EN depth tracking
// DEPTH_W      11    width of depth counter; must hold 0..STACK_DEPTH
// PORTS
// clk           in   1  clock, rising edge
// reset         in   1  synchronous, active-high; FSM to IDLE, all outputs 0
// op_valid      in   1  decoded memory op present this cycle
// op_code       in   3  0 NOP,1 LDD,2 STD,3 PUSH,4 POP,5 CALL,6 RET,7 RTI
// irq           in   1  interrupt request, level; sampled only in IDLE
// op_ready      out  1  1 when state==IDLE and irq==0; op accepted on op_valid&op_ready
// stall         out  1  hold IF..EX; 1 whenever next_state!=IDLE, or irq blocks a valid op
// mem_read      out  1  memory read strobe
// mem_write     out  1  memory write strobe
// mem_push      out  1  decrement SP this edge
// mem_pop       out  1  increment SP this edge
// addr_sel      out  2  00 std_address, 01 ldd_address, 10 SP
// wsrc_sel      out  2  00 flags, 01 PC[31:16], 10 PC[15:0], 11 reg data
// pc_from_mem   out  1  select 32-bit shift register as next PC
// int_vector    out  1  force next PC to 0 (interrupt entry)
// flags_restore out  1  restore flags from memory read data this cycle
// stack_fault   out  1  sticky overflow/underflow flag (STACK_GUARD_EN only, else 0)
// BEHAVIOUR
// - Outputs are Mealy: decoded from state plus accepted op in IDLE. Defaults are 0, addr_sel=00, wsrc_sel=00.
// - States: IDLE, CALL_LO, RET_LO, RET_HI, RET_PC, RTI_LO, INT_LO, INT_FL, INT_PC.
// - Single-cycle ops (1 cycle in IDLE, stay IDLE, stall=0):
//   - LDD: read, addr 01.
//   - STD: write, addr 00, wsrc 11.
//   - PUSH: write+push, addr 10, wsrc 11.
//   - POP: read+pop, addr 10.
// - CALL: IDLE write+push wsrc 01 -> CALL_LO write+push wsrc 10 -> IDLE. 2 cycles.
// - RET: IDLE -> RET_LO -> RET_HI -> RET_PC. 4 cycles.
//   - IDLE: no strobes.
//   - RET_LO: read+pop addr 10 (low word).
//   - RET_HI: read+pop addr 10 (high word). Shift reg now = {hi,lo}.
//   - RET_PC: pc_from_mem=1 -> IDLE.
// - RTI: IDLE read+pop+flags_restore addr 10 -> RTI_LO read+pop -> RET_HI -> RET_PC. 4 cycles.
// - irq in IDLE beats op_valid: op_ready=0 and the op is held upstream. Sequence, 4 cycles:
//   - IDLE: write+push wsrc 01.
//   - INT_LO: write+push wsrc 10.
//   - INT_FL: write+push wsrc 00.
//   - INT_PC: int_vector=1 -> IDLE.
// - irq in non-IDLE states is ignored until return to IDLE, so no nested entry mid-sequence.
// - Stack order is fixed: push hi, lo, flags; pop flags, lo, hi.
// - NOP or op_valid=0 in IDLE: all strobes 0.
// - Reset mid-sequence: IDLE next edge, partial stack contents abandoned.
// - stall is combinational. Upstream must keep op_valid/op_code stable while stall=1.
// CONFIGURATION
// - STACK_GUARD_EN defined:
//   - DEPTH_W counter: +1 on push, -1 on pop; reset 0.
//   - Push at depth==STACK_DEPTH, or pop at depth==0: suppress that cycle's write/read/push/pop, set stack_fault.
//   - On a fault, return to IDLE immediately; stack_fault clears only on reset.
// - STACK_GUARD_EN undefined: no counter, stack_fault tied 0, strobes never suppressed.
// TESTING
// - reset=1 two cycles -> all outputs 0, op_ready=1. Reset during INT_FL -> IDLE next cycle, strobes 0.
// - LDD op 1 -> one cycle mem_read=1, addr_sel=01, stall=0. STD op 2 -> mem_write=1, wsrc_sel=11.
// - CALL, PC=0x0001_0040, memory model -> writes 0x0001 then 0x0040; SP down 2; stall high cycle 1 only.
// - RET after that CALL -> pops 0x0040 then 0x0001; pc_from_mem in cycle 4; shift reg = 0x0001_0040; SP restored.
// - irq with op_valid=CALL in IDLE -> pushes PC hi, PC lo, flags=3'b101; int_vector cycle 4; CALL accepted cycle 5.
// - STACK_GUARD_EN, STACK_DEPTH=2: CALL then PUSH -> PUSH suppressed, stack_fault=1; POP at depth 0 faults too.

Source files
------------

// File: rtl/mem_stage_sequencer.sv
// Memory-stage control sequencer: per-cycle strobes for LDD/STD/PUSH/POP/CALL/RET/RTI and irq entry.
// Optional stack depth guard enabled by defining STACK_GUARD_EN.
`timescale 1ns/1ps
module mem_stage_sequencer #(
  parameter int STACK_DEPTH = 1024,
  parameter int DEPTH_W     = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  input  logic [2:0] op_code,
  input  logic       irq,
  output logic       op_ready,
  output logic       stall,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_push,
  output logic       mem_pop,
  output logic [1:0] addr_sel,
  output logic [1:0] wsrc_sel,
  output logic       pc_from_mem,
  output logic       int_vector,
  output logic       flags_restore,
  output logic       stack_fault
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] CALL_LO = 4'd1;
  localparam logic [3:0] RET_LO  = 4'd2;
  localparam logic [3:0] RET_HI  = 4'd3;
  localparam logic [3:0] RET_PC  = 4'd4;
  localparam logic [3:0] RTI_LO  = 4'd5;
  localparam logic [3:0] INT_LO  = 4'd6;
  localparam logic [3:0] INT_FL  = 4'd7;
  localparam logic [3:0] INT_PC  = 4'd8;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LDD  = 3'd1;
  localparam logic [2:0] OP_STD  = 3'd2;
  localparam logic [2:0] OP_PUSH = 3'd3;
  localparam logic [2:0] OP_POP  = 3'd4;
  localparam logic [2:0] OP_CALL = 3'd5;
  localparam logic [2:0] OP_RET  = 3'd6;
  localparam logic [2:0] OP_RTI  = 3'd7;

  localparam logic [1:0] A_STD = 2'b00;
  localparam logic [1:0] A_LDD = 2'b01;
  localparam logic [1:0] A_SP  = 2'b10;

  localparam logic [1:0] W_FLG = 2'b00;
  localparam logic [1:0] W_PCH = 2'b01;
  localparam logic [1:0] W_PCL = 2'b10;
  localparam logic [1:0] W_REG = 2'b11;

  // The depth counter must be able to hold STACK_DEPTH itself.
  if (STACK_DEPTH < 1 || STACK_DEPTH >= (1 << DEPTH_W)) begin : g_bad_depth
    $error("DEPTH_W too narrow for STACK_DEPTH");
  end

  logic [3:0] state;
  logic [3:0] next_raw;
  logic [3:0] next_state;

  logic       rd_raw;
  logic       wr_raw;
  logic       psh_raw;
  logic       pop_raw;
  logic       pcm_raw;
  logic       iv_raw;
  logic       fr_raw;
  logic [1:0] addr_raw;
  logic [1:0] wsrc_raw;

  logic       fault_now;
  logic       fault_q;
  logic       live;

  // Decode state plus the op accepted in IDLE into raw strobes and next state.
  always_comb begin
    next_raw = state;
    rd_raw   = 1'b0;
    wr_raw   = 1'b0;
    psh_raw  = 1'b0;
    pop_raw  = 1'b0;
    pcm_raw  = 1'b0;
    iv_raw   = 1'b0;
    fr_raw   = 1'b0;
    addr_raw = A_STD;
    wsrc_raw = W_FLG;
    case (state)
      IDLE: begin
        if (irq) begin
          wr_raw   = 1'b1;
          psh_raw  = 1'b1;
          addr_raw = A_SP;
          wsrc_raw = W_PCH;
          next_raw = INT_LO;
        end else if (op_valid) begin
          unique case (op_code)
            OP_NOP: begin
            end
            OP_LDD: begin
              rd_raw   = 1'b1;
              addr_raw = A_LDD;
            end
            OP_STD: begin
              wr_raw   = 1'b1;
              addr_raw = A_STD;
              wsrc_raw = W_REG;
            end
            OP_PUSH: begin
              wr_raw   = 1'b1;
              psh_raw  = 1'b1;
              addr_raw = A_SP;
              wsrc_raw = W_REG;
            end
            OP_POP: begin
              rd_raw   = 1'b1;
              pop_raw  = 1'b1;
              addr_raw = A_SP;
            end
            OP_CALL: begin
              wr_raw   = 1'b1;
              psh_raw  = 1'b1;
              addr_raw = A_SP;
              wsrc_raw = W_PCH;
              next_raw = CALL_LO;
            end
            OP_RET: begin
              next_raw = RET_LO;
            end
            OP_RTI: begin
              rd_raw   = 1'b1;
              pop_raw  = 1'b1;
              fr_raw   = 1'b1;
              addr_raw = A_SP;
              next_raw = RTI_LO;
            end
          endcase
        end
      end
      CALL_LO: begin
        wr_raw   = 1'b1;
        psh_raw  = 1'b1;
        addr_raw = A_SP;
        wsrc_raw = W_PCL;
        next_raw = IDLE;
      end
      RET_LO: begin
        rd_raw   = 1'b1;
        pop_raw  = 1'b1;
        addr_raw = A_SP;
        next_raw = RET_HI;
      end
      RTI_LO: begin
        rd_raw   = 1'b1;
        pop_raw  = 1'b1;
        addr_raw = A_SP;
        next_raw = RET_HI;
      end
      RET_HI: begin
        rd_raw   = 1'b1;
        pop_raw  = 1'b1;
        addr_raw = A_SP;
        next_raw = RET_PC;
      end
      RET_PC: begin
        pcm_raw  = 1'b1;
        next_raw = IDLE;
      end
      INT_LO: begin
        wr_raw   = 1'b1;
        psh_raw  = 1'b1;
        addr_raw = A_SP;
        wsrc_raw = W_PCL;
        next_raw = INT_FL;
      end
      INT_FL: begin
        wr_raw   = 1'b1;
        psh_raw  = 1'b1;
        addr_raw = A_SP;
        wsrc_raw = W_FLG;
        next_raw = INT_PC;
      end
      INT_PC: begin
        iv_raw   = 1'b1;
        next_raw = IDLE;
      end
      default: begin
        next_raw = IDLE;
      end
    endcase
  end

`ifdef STACK_GUARD_EN
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

  logic [DEPTH_W-1:0] depth;

  assign fault_now = (psh_raw && (depth == DEPTH_MAX)) ||
                     (pop_raw && (depth == '0));

  // Track stack occupancy; a faulting access leaves depth untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth   <= '0;
      fault_q <= 1'b0;
    end else if (fault_now) begin
      fault_q <= 1'b1;
    end else if (psh_raw) begin
      depth <= depth + DEPTH_W'(1);
    end else if (pop_raw) begin
      depth <= depth - DEPTH_W'(1);
    end
  end
`else
  assign fault_now = 1'b0;
  assign fault_q   = 1'b0;
`endif

  // A fault abandons the sequence and drops back to IDLE.
  always_comb begin
    next_state = fault_now ? IDLE : next_raw;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Output stage: strobes held low in reset, stack strobes masked on a fault.
  always_comb begin
    live          = ~reset;
    op_ready      = (state == IDLE) && !irq;
    stall         = live && ((next_state != IDLE) ||
                             ((state == IDLE) && irq && op_valid));
    mem_read      = live && rd_raw  && !fault_now;
    mem_write     = live && wr_raw  && !fault_now;
    mem_push      = live && psh_raw && !fault_now;
    mem_pop       = live && pop_raw && !fault_now;
    flags_restore = live && fr_raw  && !fault_now;
    pc_from_mem   = live && pcm_raw;
    int_vector    = live && iv_raw;
    addr_sel      = live ? addr_raw : A_STD;
    wsrc_sel      = live ? wsrc_raw : W_FLG;
    stack_fault   = live && fault_q;
  end

endmodule

// File: tb/tb_mem_stage_sequencer.sv
// Bench for mem_stage_sequencer: directed steps feed a scoreboard; a negedge monitor checks
// strobes and drives a small stack memory / SP / PC shift-register model.
`timescale 1ns/1ps
module tb_mem_stage_sequencer;

  typedef struct packed {
    logic       rdy;
    logic       stl;
    logic       rd;
    logic       wr;
    logic       psh;
    logic       pop;
    logic [1:0] addr;
    logic [1:0] wsrc;
    logic       pcm;
    logic       iv;
    logic       fr;
    logic       flt;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       op_valid = 1'b0;
  logic [2:0] op_code = 3'd0;
  logic       irq = 1'b0;
  logic       op_ready, stall, mem_read, mem_write, mem_push, mem_pop;
  logic [1:0] addr_sel, wsrc_sel;
  logic       pc_from_mem, int_vector, flags_restore, stack_fault;

  mem_stage_sequencer #(.STACK_DEPTH(2), .DEPTH_W(11)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .irq(irq), .op_ready(op_ready), .stall(stall),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_push(mem_push), .mem_pop(mem_pop),
    .addr_sel(addr_sel), .wsrc_sel(wsrc_sel),
    .pc_from_mem(pc_from_mem), .int_vector(int_vector),
    .flags_restore(flags_restore), .stack_fault(stack_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;

  exp_t        eq[$];
  string       nq[$];
  logic [15:0] wq[$];
  logic [15:0] rq[$];
  logic [31:0] pq[$];

  logic [31:0] pc = 32'h0001_0040;
  logic [2:0]  flags_in = 3'b101;
  logic [15:0] regd = 16'hBEEF;

  logic [15:0] sp = 16'h0100;
  logic [15:0] mem [0:511];
  logic [31:0] shreg = 32'h0;
  logic [2:0]  flags_rst = 3'b000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic exp_t ex(input logic rdy, stl, rd, wr, ps, pp,
                              input logic [1:0] a, w,
                              input logic pcm, iv, fr, fl);
    ex = {rdy, stl, rd, wr, ps, pp, a, w, pcm, iv, fr, fl};
  endfunction

  task automatic step(input string nm, input logic v, input logic [2:0] c,
                      input logic i, input logic r, input exp_t x);
    @(posedge clk);
    #1;
    op_valid = v;
    op_code  = c;
    irq      = i;
    reset    = r;
    eq.push_back(x);
    nq.push_back(nm);
  endtask

  // Monitor: compare strobes, then apply them to the stack/PC model.
  always @(negedge clk) begin
    exp_t got;
    exp_t x;
    string nm;
    logic [15:0] wd;
    logic [15:0] rdv;
    logic [15:0] spn;
    got = {op_ready, stall, mem_read, mem_write, mem_push, mem_pop,
           addr_sel, wsrc_sel, pc_from_mem, int_vector,
           flags_restore, stack_fault};
    if (eq.size() != 0) begin
      x  = eq.pop_front();
      nm = nq.pop_front();
      checks++;
      if (got !== x) begin
        fails++;
        $display("FAIL %s: got %b want %b", nm, got, x);
      end
    end
    if (mem_write === 1'b1) begin
      case (wsrc_sel)
        2'b00:   wd = {13'h0, flags_in};
        2'b01:   wd = pc[31:16];
        2'b10:   wd = pc[15:0];
        default: wd = regd;
      endcase
      if (wq.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected write: got %h want none", wd);
      end else begin
        chk("write data", {16'h0, wd}, {16'h0, wq.pop_front()});
      end
      if (addr_sel == 2'b10) mem[sp[8:0]] = wd;
    end
    if (mem_push === 1'b1) sp = sp - 16'd1;
    if (mem_read === 1'b1 && addr_sel == 2'b10) begin
      spn = sp + 16'd1;
      rdv = mem[spn[8:0]];
      if (rq.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected stack read: got %h want none", rdv);
      end else begin
        chk("stack read", {16'h0, rdv}, {16'h0, rq.pop_front()});
      end
      shreg = {rdv, shreg[31:16]};
      if (flags_restore === 1'b1) flags_rst = rdv[2:0];
    end
    if (mem_pop === 1'b1) sp = sp + 16'd1;
    if (pc_from_mem === 1'b1) begin
      if (pq.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected pc_from_mem: got %h want none", shreg);
      end else begin
        chk("pc from stack", shreg, pq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    step("reset", 0, 0, 0, 1, ex(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    step("idle",  0, 0, 0, 0, ex(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    step("nop",   1, 0, 0, 0, ex(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    step("ldd",   1, 1, 0, 0, ex(1,0,1,0,0,0,2'b01,2'b00,0,0,0,0));
    wq.push_back(16'hBEEF);
    step("std",   1, 2, 0, 0, ex(1,0,0,1,0,0,2'b00,2'b11,0,0,0,0));

    wq.push_back(16'h0001);
    step("call_c1", 1, 5, 0, 0, ex(1,1,0,1,1,0,2'b10,2'b01,0,0,0,0));
    wq.push_back(16'h0040);
    step("call_c2", 1, 5, 0, 0, ex(0,0,0,1,1,0,2'b10,2'b10,0,0,0,0));
    step("ret_c1",  1, 6, 0, 0, ex(1,1,0,0,0,0,2'b00,2'b00,0,0,0,0));
    chk("sp after call", {16'h0, sp}, 32'h0000_00FE);
    rq.push_back(16'h0040);
    step("ret_c2",  1, 6, 0, 0, ex(0,1,1,0,0,1,2'b10,2'b00,0,0,0,0));
    rq.push_back(16'h0001);
    step("ret_c3",  1, 6, 0, 0, ex(0,1,1,0,0,1,2'b10,2'b00,0,0,0,0));
    pq.push_back(32'h0001_0040);
    step("ret_c4",  1, 6, 0, 0, ex(0,0,0,0,0,0,2'b00,2'b00,1,0,0,0));
    step("idle2",   0, 0, 0, 0, ex(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    chk("sp after ret", {16'h0, sp}, 32'h0000_0100);

    wq.push_back(16'hBEEF);
    step("push", 1, 3, 0, 0, ex(1,0,0,1,1,0,2'b10,2'b11,0,0,0,0));
    rq.push_back(16'hBEEF);
    step("pop",  1, 4, 0, 0, ex(1,0,1,0,0,1,2'b10,2'b00,0,0,0,0));

    wq.push_back(16'h0001);
    step("irq_c1", 1, 5, 1, 0, ex(0,1,0,1,1,0,2'b10,2'b01,0,0,0,0));
    wq.push_back(16'h0040);
    step("irq_c2", 1, 5, 1, 0, ex(0,1,0,1,1,0,2'b10,2'b10,0,0,0,0));
    wq.push_back(16'h0005);
    step("irq_c3", 1, 5, 0, 0, ex(0,1,0,1,1,0,2'b10,2'b00,0,0,0,0));
    step("irq_c4", 1, 5, 0, 0, ex(0,0,0,0,0,0,2'b00,2'b00,0,1,0,0));
    pc = 32'h0002_0080;
    wq.push_back(16'h0002);
    step("call_after_irq", 1, 5, 0, 0, ex(1,1,0,1,1,0,2'b10,2'b01,0,0,0,0));
    chk("sp after irq", {16'h0, sp}, 32'h0000_00FD);
    wq.push_back(16'h0080);
    step("call2_c2", 1, 5, 0, 0, ex(0,0,0,1,1,0,2'b10,2'b10,0,0,0,0));
    step("ret2_c1",  1, 6, 0, 0, ex(1,1,0,0,0,0,2'b00,2'b00,0,0,0,0));
    chk("sp in handler", {16'h0, sp}, 32'h0000_00FB);
    rq.push_back(16'h0080);
    step("ret2_c2",  1, 6, 0, 0, ex(0,1,1,0,0,1,2'b10,2'b00,0,0,0,0));
    rq.push_back(16'h0002);
    step("ret2_c3",  1, 6, 0, 0, ex(0,1,1,0,0,1,2'b10,2'b00,0,0,0,0));
    pq.push_back(32'h0002_0080);
    step("ret2_c4",  1, 6, 0, 0, ex(0,0,0,0,0,0,2'b00,2'b00,1,0,0,0));

    pc = 32'h0001_0040;
    rq.push_back(16'h0005);
    step("rti_c1", 1, 7, 0, 0, ex(1,1,1,0,0,1,2'b10,2'b00,0,0,1,0));
    rq.push_back(16'h0040);
    step("rti_c2", 1, 7, 0, 0, ex(0,1,1,0,0,1,2'b10,2'b00,0,0,0,0));
    rq.push_back(16'h0001);
    step("rti_c3", 1, 7, 0, 0, ex(0,1,1,0,0,1,2'b10,2'b00,0,0,0,0));
    pq.push_back(32'h0001_0040);
    step("rti_c4", 1, 7, 0, 0, ex(0,0,0,0,0,0,2'b00,2'b00,1,0,0,0));
    step("idle3",  0, 0, 0, 0, ex(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    chk("sp after rti", {16'h0, sp}, 32'h0000_0100);
    chk("flags restored", {29'h0, flags_rst}, 32'h0000_0005);

    wq.push_back(16'h0001);
    step("rirq_c1", 0, 0, 1, 0, ex(0,1,0,1,1,0,2'b10,2'b01,0,0,0,0));
    wq.push_back(16'h0040);
    step("rirq_c2", 0, 0, 1, 0, ex(0,1,0,1,1,0,2'b10,2'b10,0,0,0,0));
    step("reset_in_int_fl", 0, 0, 0, 1, ex(0,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    step("after_reset",     0, 0, 0, 0, ex(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    chk("sp after abandon", {16'h0, sp}, 32'h0000_00FE);

    wq.push_back(16'h0001);
    step("g_call_c1", 1, 5, 0, 0, ex(1,1,0,1,1,0,2'b10,2'b01,0,0,0,0));
    wq.push_back(16'h0040);
    step("g_call_c2", 1, 5, 0, 0, ex(0,0,0,1,1,0,2'b10,2'b10,0,0,0,0));
`ifdef STACK_GUARD_EN
    step("g_push_ovf",  1, 3, 0, 0, ex(1,0,0,0,0,0,2'b10,2'b11,0,0,0,0));
    step("g_fault_set", 0, 0, 0, 0, ex(1,0,0,0,0,0,2'b00,2'b00,0,0,0,1));
    chk("sp after ovf", {16'h0, sp}, 32'h0000_00FC);
    step("g_reset",     0, 0, 0, 1, ex(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    step("g_pop_unf",   1, 4, 0, 0, ex(1,0,0,0,0,0,2'b10,2'b00,0,0,0,0));
    step("g_fault_unf", 0, 0, 0, 0, ex(1,0,0,0,0,0,2'b00,2'b00,0,0,0,1));
    step("g_ret_c1",    1, 6, 0, 0, ex(1,1,0,0,0,0,2'b00,2'b00,0,0,0,1));
    step("g_ret_lo_unf", 1, 6, 0, 0, ex(0,0,0,0,0,0,2'b10,2'b00,0,0,0,1));
    step("g_back_idle", 0, 0, 0, 0, ex(1,0,0,0,0,0,2'b00,2'b00,0,0,0,1));
    chk("sp after unf", {16'h0, sp}, 32'h0000_00FC);
`else
    wq.push_back(16'hBEEF);
    step("g_push_free", 1, 3, 0, 0, ex(1,0,0,1,1,0,2'b10,2'b11,0,0,0,0));
    step("g_no_fault",  0, 0, 0, 0, ex(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    chk("sp after push", {16'h0, sp}, 32'h0000_00FB);
    step("g_reset",     0, 0, 0, 1, ex(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    rq.push_back(16'hBEEF);
    step("g_pop_free",  1, 4, 0, 0, ex(1,0,1,0,0,1,2'b10,2'b00,0,0,0,0));
    step("g_idle",      0, 0, 0, 0, ex(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    chk("sp after pop", {16'h0, sp}, 32'h0000_00FC);
`endif

    repeat (3) @(posedge clk);
    chk("queues drained",
        32'(eq.size() + wq.size() + rq.size() + pq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
